// File: rtl/seqgen_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
package seqgen_pkg;

    localparam int unsigned SEQGEN_MAX_LEN = 16;
    localparam int unsigned SEQGEN_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seqgen_state_t;

endpackage

// File: rtl/seqgen_down_counter.sv
// Loadable down-counter that saturates at zero; used for bit index, repeats and gap.
module seqgen_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement stops at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated
// N times with a filler gap between instances. Outputs are registered.
module sequence_generator
    import seqgen_pkg::*;
#(
    parameter int unsigned MAX_LEN = SEQGEN_MAX_LEN,
    parameter int unsigned CNT_W   = SEQGEN_CNT_W,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [CNT_W-1:0]   repeat_cnt,
    input  logic [CNT_W-1:0]   gap_len,
    input  logic               gap_bit,
    output logic               data_out,
    output logic               data_valid,
    output logic               busy,
    output logic               seq_end,
    output logic               done
);

    seqgen_state_t state_q, state_d;

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   gap_len_q, gap_len_d;
    logic               gap_bit_q, gap_bit_d;

    logic data_out_q, data_out_d;
    logic data_valid_q, data_valid_d;
    logic busy_q, busy_d;
    logic seq_end_q, seq_end_d;
    logic done_q, done_d;

    logic [LEN_W-1:0]   len_clamped;
    logic               params_ok;
    logic               accept_c;
    logic               finish_c;

    logic               bit_load_c, bit_dec_c, bit_zero;
    logic [LEN_W-1:0]   bit_load_val_c, bit_idx_q, bit_idx_d;
    logic               rep_load_c, rep_dec_c, rep_zero;
    logic [CNT_W-1:0]   rep_cnt_unused;
    logic               gap_load_c, gap_dec_c, gap_zero;
    logic [CNT_W-1:0]   gap_cnt_unused;
    logic [MAX_LEN-1:0] pat_shift;

    assign len_clamped = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
    assign params_ok   = (pat_len != '0) && (repeat_cnt != '0);

    // Bit counter holds the index of the bit currently on the line.
    seqgen_down_counter #(.W(LEN_W)) u_bit_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bit_load_c),
        .load_val_i (bit_load_val_c),
        .dec_i      (bit_dec_c),
        .count_o    (bit_idx_q),
        .zero_o     (bit_zero)
    );

    // Repeat counter holds instances still to send after the current one.
    seqgen_down_counter #(.W(CNT_W)) u_rep_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (rep_load_c),
        .load_val_i (repeat_cnt - CNT_W'(1)),
        .dec_i      (rep_dec_c),
        .count_o    (rep_cnt_unused),
        .zero_o     (rep_zero)
    );

    // Gap counter holds gap cycles remaining after the current one.
    seqgen_down_counter #(.W(CNT_W)) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gap_load_c),
        .load_val_i (gap_len_q - CNT_W'(1)),
        .dec_i      (gap_dec_c),
        .count_o    (gap_cnt_unused),
        .zero_o     (gap_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            gap_len_q    <= '0;
            gap_bit_q    <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            seq_end_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            gap_len_q    <= gap_len_d;
            gap_bit_q    <= gap_bit_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            seq_end_q    <= seq_end_d;
            done_q       <= done_d;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_d        = state_q;
        accept_c       = 1'b0;
        finish_c       = 1'b0;
        bit_load_c     = 1'b0;
        bit_load_val_c = len_q - LEN_W'(1);
        bit_dec_c      = 1'b0;
        rep_load_c     = 1'b0;
        rep_dec_c      = 1'b0;
        gap_load_c     = 1'b0;
        gap_dec_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (params_ok) begin
                        accept_c       = 1'b1;
                        state_d        = SEND;
                        bit_load_c     = 1'b1;
                        bit_load_val_c = len_clamped - LEN_W'(1);
                        rep_load_c     = 1'b1;
                    end else begin
                        finish_c = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!bit_zero) begin
                    bit_dec_c = 1'b1;
                end else if (rep_zero) begin
                    state_d  = IDLE;
                    finish_c = 1'b1;
                end else begin
                    rep_dec_c = 1'b1;
                    if (gap_len_q != '0) begin
                        state_d    = GAP;
                        gap_load_c = 1'b1;
                    end else begin
                        bit_load_c = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_d    = SEND;
                    bit_load_c = 1'b1;
                end else begin
                    gap_dec_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and data-register next values, derived from the next state.
    always_comb begin
        pat_d     = accept_c ? pat         : pat_q;
        len_d     = accept_c ? len_clamped : len_q;
        gap_len_d = accept_c ? gap_len     : gap_len_q;
        gap_bit_d = accept_c ? gap_bit     : gap_bit_q;

        bit_idx_d = bit_idx_q;
        if (bit_load_c) begin
            bit_idx_d = bit_load_val_c;
        end else if (bit_dec_c) begin
            bit_idx_d = bit_idx_q - LEN_W'(1);
        end
        pat_shift = pat_d >> bit_idx_d;

        data_out_d   = 1'b0;
        data_valid_d = 1'b0;
        busy_d       = 1'b0;
        seq_end_d    = 1'b0;
        done_d       = finish_c;
        case (state_d)
            SEND: begin
                data_out_d   = pat_shift[0];
                data_valid_d = 1'b1;
                busy_d       = 1'b1;
                seq_end_d    = (bit_idx_d == '0);
            end
            GAP: begin
                data_out_d   = gap_bit_d;
                data_valid_d = 1'b1;
                busy_d       = 1'b1;
            end
            default: ;
        endcase
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign seq_end    = seq_end_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench: a run-level model expands each accepted start into expected per-cycle outputs.
module tb_sequence_generator;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   pat_len;
    logic [CNT_W-1:0]   repeat_cnt;
    logic [CNT_W-1:0]   gap_len;
    logic               gap_bit;
    logic               data_out, data_valid, busy, seq_end, done;

    always #5 clk = ~clk;

    sequence_generator #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pat        (pat),
        .pat_len    (pat_len),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .gap_bit    (gap_bit),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .seq_end    (seq_end),
        .done       (done)
    );

    // bits = {data_out, data_valid, busy, seq_end, done} seen after edge edge_n
    typedef struct {
        int unsigned edge_n;
        logic [4:0]  bits;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_cnt  = 0;
    int unsigned next_free = 0;
    bit          mon_en    = 1'b0;
    int          checks    = 0;
    int          errors    = 0;

    task automatic push(input int unsigned e, input logic [4:0] b);
        exp_t x;
        x.edge_n = e;
        x.bits   = b;
        exp_q.push_back(x);
    endtask

    // Expand one accepted run into its expected output stream.
    task automatic model_accept(input int unsigned k);
        int unsigned l, n, g, off;
        l   = (int'(pat_len) > MAX_LEN) ? MAX_LEN : int'(pat_len);
        n   = repeat_cnt;
        g   = gap_len;
        off = 0;
        if (l == 0 || n == 0) begin
            push(k, 5'b00001);
            next_free = k + 1;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                for (int j = 0; j < int'(l); j++) begin
                    push(k + off, {pat[l - 1 - j], 1'b1, 1'b1, (j == int'(l) - 1), 1'b0});
                    off++;
                end
                if (i < int'(n) - 1) begin
                    for (int q = 0; q < int'(g); q++) begin
                        push(k + off, {gap_bit, 1'b1, 1'b1, 1'b0, 1'b0});
                        off++;
                    end
                end
            end
            push(k + off, 5'b00001);
            next_free = k + off + 1;
        end
    endtask

    always @(posedge clk) begin
        edge_cnt++;
        if (reset) begin
            exp_q.delete();
            next_free = edge_cnt + 1;
            mon_en    = 1'b1;
        end else if (start && edge_cnt >= next_free) begin
            model_accept(edge_cnt);
        end
    end

    // Monitor: every cycle is compared, idle cycles against all-zero.
    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] want, got;
        if (mon_en) begin
            want = 5'b00000;
            if (exp_q.size() > 0 && exp_q[0].edge_n == edge_cnt) begin
                e    = exp_q.pop_front();
                want = e.bits;
            end
            got = {data_out, data_valid, busy, seq_end, done};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs after edge %0d: got dout/valid/busy/end/done=%b want %b",
                         edge_cnt, got, want);
            end
        end
    end

    task automatic set_in(input logic [MAX_LEN-1:0] p, input int unsigned l, input int unsigned n,
                          input int unsigned g, input logic gb);
        pat        = p;
        pat_len    = LEN_W'(l);
        repeat_cnt = CNT_W'(n);
        gap_len    = CNT_W'(g);
        gap_bit    = gb;
    endtask

    task automatic scramble();
        set_in(MAX_LEN'($urandom), $urandom_range(0, 20), $urandom_range(0, 5),
               $urandom_range(0, 4), 1'($urandom));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: %0d expected entries left, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Single start pulse; controls are scrambled right after to prove they were latched.
    task automatic pulse_run(input logic [MAX_LEN-1:0] p, input int unsigned l, input int unsigned n,
                             input int unsigned g, input logic gb);
        @(negedge clk);
        set_in(p, l, n, g, gb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        drain();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_in('0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-run aborts with no done pulse.
        set_in(16'hB, 4, 3, 2, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drain();

        pulse_run(16'b1011, 4, 1, 0, 1'b0);
        pulse_run(16'b110, 3, 2, 2, 1'b0);
        pulse_run(16'b10, 2, 3, 0, 1'b1);
        pulse_run(16'hA5C3, 0, 2, 1, 1'b1);
        pulse_run(16'hBEEF, 20, 1, 0, 1'b0);
        pulse_run(16'hBEEF, 20, 2, 3, 1'b1);
        pulse_run(16'h1234, 5, 0, 1, 1'b0);
        pulse_run(16'h0001, 1, 4, 9, 1'b1);
        pulse_run(16'hFFFF, 16, 2, 1, 1'b0);

        // Start held high: ignored while busy, re-accepted in each done cycle.
        @(negedge clk);
        set_in(16'b10, 2, 2, 1, 1'b1);
        start = 1'b1;
        repeat (25) @(negedge clk);
        set_in(16'h3, 0, 1, 0, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain();

        // Randomized traffic, including starts while busy and occasional resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            scramble();
            start = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        drain();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover expectations: %0d, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
